// File: rtl/io_pad_mux_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | io_pad_mux_pkg                                                             |
// | Register map, lock key and PADCFG field layout shared by the pad mux.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package io_pad_mux_pkg;

  localparam int ADR_LSB = 2;
  localparam int ADR_MSB = 9;

  localparam logic [7:0] LOCK_WORD = 8'h40;  // byte offset 0x100
  localparam logic [7:0] LOCK_KEY  = 8'hA5;

  localparam int CFG_FORCE_BIT  = 8;
  localparam int CFG_BYPASS_BIT = 9;
  localparam int CFG_IDLE_BIT   = 10;

  typedef enum logic [1:0] {
    DEC_PAD  = 2'd0,
    DEC_LOCK = 2'd1,
    DEC_NONE = 2'd2
  } dec_e;

  typedef struct packed {
    logic force_in;
    logic bypass;
    logic idle;
  } pad_flags_t;

  function automatic logic [31:0] pack_cfg(input logic [7:0] sel_byte, input pad_flags_t f);
    return {21'b0, f.idle, f.bypass, f.force_in, sel_byte};
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_pad_cell.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | io_pad_cell                                                                |
// | One pad: config register, turnaround counter, synchroniser, output flops.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module io_pad_cell
  import io_pad_mux_pkg::*;
#(
  parameter int NUM_FUNCS = 4,
  parameter int SEL_W     = 2,
  parameter int TURN_CYC  = 2,
  parameter int RESET_SEL = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_wr_en,
  input  logic [1:0]           i_wr_be,
  input  logic [SEL_W-1:0]     i_wr_sel,
  input  pad_flags_t           i_wr_flags,
  input  logic [NUM_FUNCS-1:0] i_func_out,
  input  logic [NUM_FUNCS-1:0] i_func_oeb,
  output logic [NUM_FUNCS-1:0] o_func_in,
  input  logic                 i_io_in,
  output logic                 o_io_out,
  output logic                 o_io_oeb,
  output logic [31:0]          o_cfg
);

  localparam int                CNT_W     = (TURN_CYC < 1) ? 1 : $clog2(TURN_CYC + 1);
  localparam logic [SEL_W-1:0]  RST_SEL   = SEL_W'(RESET_SEL);
  localparam logic [CNT_W-1:0]  TURN_LOAD = CNT_W'(TURN_CYC);

  logic [SEL_W-1:0] sel_q, sel_d;
  pad_flags_t       flags_q, flags_d;
  logic [CNT_W-1:0] turn_q, turn_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             io_out_q, io_out_d;
  logic             io_oeb_q, io_oeb_d;

  logic             w_mux_out;
  logic             w_mux_oeb;
  logic             w_turning;
  logic             w_pad_val;

  assign w_turning = (turn_q != '0);

  // A select outside the implemented functions drives nothing and leaves the pad an input.
  always_comb begin
    w_mux_out = 1'b0;
    w_mux_oeb = 1'b1;
    for (int f = 0; f < NUM_FUNCS; f++) begin
      if (sel_q == SEL_W'(f)) begin
        w_mux_out = i_func_out[f];
        w_mux_oeb = i_func_oeb[f];
      end
    end
  end

  always_comb begin
    sel_d   = sel_q;
    flags_d = flags_q;
    turn_d  = w_turning ? turn_q - CNT_W'(1) : turn_q;
    if (i_wr_en) begin
      if (i_wr_be[0]) begin
        sel_d = i_wr_sel;
        if (i_wr_sel != sel_q) begin
          turn_d = TURN_LOAD;
        end
      end
      if (i_wr_be[1]) begin
        flags_d = i_wr_flags;
      end
    end
    io_out_d = w_mux_out & ~w_turning;
    io_oeb_d = w_mux_oeb | flags_q.force_in | w_turning;
    sync1_d  = i_io_in;
    sync2_d  = sync1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q    <= RST_SEL;
      flags_q  <= '0;
      turn_q   <= '0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      io_out_q <= 1'b0;
      io_oeb_q <= 1'b1;
    end else begin
      sel_q    <= sel_d;
      flags_q  <= flags_d;
      turn_q   <= turn_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      io_out_q <= io_out_d;
      io_oeb_q <= io_oeb_d;
    end
  end

  // Input delivery ignores the turnaround so input functions never see a gap.
  assign w_pad_val = flags_q.bypass ? i_io_in : sync2_q;

  for (genvar f = 0; f < NUM_FUNCS; f++) begin : g_func
    assign o_func_in[f] = (sel_q == SEL_W'(f)) ? w_pad_val : flags_q.idle;
  end

  assign o_io_out = io_out_q;
  assign o_io_oeb = io_oeb_q;
  assign o_cfg    = pack_cfg(8'(sel_q), flags_q);

endmodule
`default_nettype wire

// File: rtl/io_pad_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | io_pad_mux                                                                 |
// | Wishbone-configured pad multiplexer: decode, lock bit, readback, pad array.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module io_pad_mux
  import io_pad_mux_pkg::*;
#(
  parameter int NUM_PADS  = 38,
  parameter int NUM_FUNCS = 4,
  parameter int TURN_CYC  = 2,
  parameter int RESET_SEL = 0
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          wbs_stb_i,
  input  logic                          wbs_cyc_i,
  input  logic                          wbs_we_i,
  input  logic [3:0]                    wbs_sel_i,
  input  logic [31:0]                   wbs_adr_i,
  input  logic [31:0]                   wbs_dat_i,
  output logic                          wbs_ack_o,
  output logic [31:0]                   wbs_dat_o,
  input  logic [NUM_FUNCS*NUM_PADS-1:0] func_out,
  input  logic [NUM_FUNCS*NUM_PADS-1:0] func_oeb,
  output logic [NUM_FUNCS*NUM_PADS-1:0] func_in,
  input  logic [NUM_PADS-1:0]           io_in,
  output logic [NUM_PADS-1:0]           io_out,
  output logic [NUM_PADS-1:0]           io_oeb
);

  localparam int SEL_W = (NUM_FUNCS > 1) ? $clog2(NUM_FUNCS) : 1;

  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        lock_q, lock_d;

  logic [7:0]       w_word;
  logic             w_req;
  logic             w_wr;
  logic             w_cfg_wr;
  dec_e             w_dec;
  pad_flags_t       w_wr_flags;
  logic [SEL_W-1:0] w_wr_sel;
  logic [31:0]      w_cfg [NUM_PADS];
  logic             w_unused;

  assign w_word   = wbs_adr_i[ADR_MSB:ADR_LSB];
  assign w_req    = wbs_stb_i & wbs_cyc_i & ~ack_q;
  assign w_wr     = w_req & wbs_we_i;
  assign w_wr_sel = wbs_dat_i[SEL_W-1:0];
  assign w_wr_flags = '{force_in: wbs_dat_i[CFG_FORCE_BIT],
                        bypass:   wbs_dat_i[CFG_BYPASS_BIT],
                        idle:     wbs_dat_i[CFG_IDLE_BIT]};
  assign w_unused = ^{wbs_dat_i[31:11], wbs_adr_i[31:10], wbs_adr_i[1:0], wbs_sel_i[3:2]};

  always_comb begin
    w_dec = DEC_NONE;
    if (w_word == LOCK_WORD) begin
      w_dec = DEC_LOCK;
    end else if (w_word < 8'(NUM_PADS)) begin
      w_dec = DEC_PAD;
    end
  end

  // Once locked, pad configuration writes still complete on the bus but are dropped here.
  assign w_cfg_wr = w_wr & ~lock_q & (w_dec == DEC_PAD);

  always_comb begin
    ack_d  = w_req;
    lock_d = lock_q;
    if (w_wr && (w_dec == DEC_LOCK) && wbs_sel_i[0] && (wbs_dat_i[7:0] == LOCK_KEY)) begin
      lock_d = 1'b1;
    end
    dat_d = 32'h0;
    if (w_req && !wbs_we_i) begin
      case (w_dec)
        DEC_PAD: begin
          for (int i = 0; i < NUM_PADS; i++) begin
            if (w_word == 8'(i)) begin
              dat_d = w_cfg[i];
            end
          end
        end
        DEC_LOCK: dat_d = {31'b0, lock_q};
        default:  dat_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q  <= 1'b0;
      dat_q  <= 32'h0;
      lock_q <= 1'b0;
    end else begin
      ack_q  <= ack_d;
      dat_q  <= dat_d;
      lock_q <= lock_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

  for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
    logic [NUM_FUNCS-1:0] w_fo;
    logic [NUM_FUNCS-1:0] w_foe;
    logic [NUM_FUNCS-1:0] w_fi;

    for (genvar f = 0; f < NUM_FUNCS; f++) begin : g_route
      assign w_fo[f]                = func_out[f*NUM_PADS+i];
      assign w_foe[f]               = func_oeb[f*NUM_PADS+i];
      assign func_in[f*NUM_PADS+i]  = w_fi[f];
    end

    io_pad_cell #(
      .NUM_FUNCS (NUM_FUNCS),
      .SEL_W     (SEL_W),
      .TURN_CYC  (TURN_CYC),
      .RESET_SEL (RESET_SEL)
    ) u_cell (
      .clk        (wb_clk_i),
      .rst        (wb_rst_i),
      .i_wr_en    (w_cfg_wr && (w_word == 8'(i))),
      .i_wr_be    (wbs_sel_i[1:0]),
      .i_wr_sel   (w_wr_sel),
      .i_wr_flags (w_wr_flags),
      .i_func_out (w_fo),
      .i_func_oeb (w_foe),
      .o_func_in  (w_fi),
      .i_io_in    (io_in[i]),
      .o_io_out   (io_out[i]),
      .o_io_oeb   (io_oeb[i]),
      .o_cfg      (w_cfg[i])
    );
  end

endmodule
`default_nettype wire
